// File: rtl/motors_step_driver_if.sv
// Trigger/ready/done handshake between the linear-op handler (master) and the
// step driver (slave), including the per-step axis enables and directions.
interface motors_step_driver_if;
   logic trigger;
   logic step_x_en;
   logic dir_x;
   logic step_y_en;
   logic dir_y;
   logic rdy;
   logic done;

   modport master (
      output trigger, step_x_en, dir_x, step_y_en, dir_y,
      input  rdy, done
   );

   modport slave (
      input  trigger, step_x_en, dir_x, step_y_en, dir_y,
      output rdy, done
   );
endinterface

// File: rtl/motors_step_driver.sv
// Single-step STEP/DIR generator for the X/Y steppers: direction setup, step
// pulse and hold, all timed in clk_en ticks, with glitch-free registered pins.
module motors_step_driver #(
   parameter int unsigned DIR_SETUP_TICKS = 2,
   parameter int unsigned PULSE_TICKS     = 10,
   parameter int unsigned HOLD_TICKS      = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clk_en,
   motors_step_driver_if.slave  bus,
   output logic                 motor_x_step,
   output logic                 motor_x_dir,
   output logic                 motor_y_step,
   output logic                 motor_y_dir
);

   localparam int unsigned SETUP_N = (DIR_SETUP_TICKS == 0) ? 1 : DIR_SETUP_TICKS;
   localparam int unsigned PULSE_N = (PULSE_TICKS == 0) ? 1 : PULSE_TICKS;
   localparam int unsigned HOLD_N  = (HOLD_TICKS == 0) ? 1 : HOLD_TICKS;
   localparam int unsigned MAX_SP  = (SETUP_N > PULSE_N) ? SETUP_N : PULSE_N;
   localparam int unsigned MAX_N   = (MAX_SP > HOLD_N) ? MAX_SP : HOLD_N;
   localparam int unsigned CNT_W   = $clog2(MAX_N + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               en_x_q, en_x_d;
   logic               en_y_q, en_y_d;
   logic               dir_x_q, dir_x_d;
   logic               dir_y_q, dir_y_d;
   logic               step_x_q, step_x_d;
   logic               step_y_q, step_y_d;
   logic               rdy_q, rdy_d;
   logic               done_q, done_d;

   always_comb begin
      // NOTE: every _d defaults to its _q first, so no branch can leave a latch behind.
      state_d  = state_q;
      cnt_d    = cnt_q;
      en_x_d   = en_x_q;
      en_y_d   = en_y_q;
      dir_x_d  = dir_x_q;
      dir_y_d  = dir_y_q;
      step_x_d = step_x_q;
      step_y_d = step_y_q;
      rdy_d    = rdy_q;
      done_d   = done_q;

      if (clk_en) begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.trigger) begin
                  state_d = ST_SETUP;
                  en_x_d  = bus.step_x_en;
                  en_y_d  = bus.step_y_en;
                  dir_x_d = bus.dir_x;
                  dir_y_d = bus.dir_y;
               end
            end
            ST_SETUP: begin
               if (cnt_q == CNT_W'(SETUP_N - 1))
                  state_d = (en_x_q || en_y_q) ? ST_PULSE : ST_HOLD;
            end
            ST_PULSE: begin
               if (cnt_q == CNT_W'(PULSE_N - 1)) state_d = ST_HOLD;
            end
            ST_HOLD: begin
               if (cnt_q == CNT_W'(HOLD_N - 1)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase

         // Timed states exit at N-1, so the counter saturates below MAX_N and never wraps.
         if (state_d != state_q)
            cnt_d = '0;
         else if (state_q inside {ST_SETUP, ST_PULSE, ST_HOLD})
            cnt_d = cnt_q + 1'b1;

         // Pins follow the next state so they are registered and glitch-free.
         step_x_d = (state_d == ST_PULSE) && en_x_q;
         step_y_d = (state_d == ST_PULSE) && en_y_q;
         rdy_d    = (state_d == ST_IDLE);
         done_d   = (state_d == ST_IDLE) || (state_d == ST_DONE);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         en_x_q   <= 1'b0;
         en_y_q   <= 1'b0;
         dir_x_q  <= 1'b0;
         dir_y_q  <= 1'b0;
         step_x_q <= 1'b0;
         step_y_q <= 1'b0;
         rdy_q    <= 1'b1;
         done_q   <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values together.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         en_x_q   <= en_x_d;
         en_y_q   <= en_y_d;
         dir_x_q  <= dir_x_d;
         dir_y_q  <= dir_y_d;
         step_x_q <= step_x_d;
         step_y_q <= step_y_d;
         rdy_q    <= rdy_d;
         done_q   <= done_d;
      end
   end

   assign motor_x_step = step_x_q;
   assign motor_x_dir  = dir_x_q;
   assign motor_y_step = step_y_q;
   assign motor_y_dir  = dir_y_q;
   assign bus.rdy      = rdy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_motors_step_driver.sv
// Scoreboard bench for motors_step_driver: a tick-level model predicts each
// accepted step, a monitor measures the pins and compares on completion.
module tb_motors_step_driver;

   localparam int S = 2;
   localparam int P = 10;
   localparam int H = 10;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic clk_en = 1'b0;
   logic mx_step, mx_dir, my_step, my_dir;

   motors_step_driver_if bus ();

   motors_step_driver #(
      .DIR_SETUP_TICKS (S),
      .PULSE_TICKS     (P),
      .HOLD_TICKS      (H)
   ) dut (
      .clk          (clk),
      .reset        (rst_n),
      .clk_en       (clk_en),
      .bus          (bus),
      .motor_x_step (mx_step),
      .motor_x_dir  (mx_dir),
      .motor_y_step (my_step),
      .motor_y_dir  (my_dir)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   typedef struct {
      logic ex;
      logic ey;
      logic dx;
      logic dy;
      int   acc_tick;
      int   lat;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: one step per accept, busy for the whole latency plus one IDLE tick.
   int   m_tick = 0;
   int   m_free = 0;
   exp_t m_e;

   always @(posedge clk) begin
      if (clk_en) m_tick++;
      if (!rst_n) begin
         exp_q.delete();
         m_free = 0;
      end else if (clk_en && bus.trigger && m_tick >= m_free) begin
         m_e.ex       = bus.step_x_en;
         m_e.ey       = bus.step_y_en;
         m_e.dx       = bus.dir_x;
         m_e.dy       = bus.dir_y;
         m_e.acc_tick = m_tick;
         m_e.lat      = (bus.step_x_en || bus.step_y_en) ? S + P + H + 1 : S + H + 1;
         exp_q.push_back(m_e);
         m_free = m_tick + m_e.lat + 1;
      end
   end

   // Monitor: measures each DUT transaction from rdy falling to done rising.
   int         mon_tick = 0;
   int         acc_tick, cnt_x, cnt_y, first_x, first_y;
   logic       in_txn = 1'b0, post_pending = 1'b0, dir_bad = 1'b0;
   logic       stray = 1'b0, nontick_chg = 1'b0, was_tick;
   logic       acc_dx, acc_dy;
   logic [5:0] prev = 6'b000011;
   logic [5:0] cur;
   exp_t       e;

   always @(posedge clk) begin
      was_tick = clk_en;
      #1;
      cur = {mx_step, mx_dir, my_step, my_dir, bus.done, bus.rdy};
      if (was_tick) mon_tick++;
      if (!rst_n) begin
         in_txn       = 1'b0;
         post_pending = 1'b0;
      end else if (!was_tick) begin
         if (cur !== prev) nontick_chg = 1'b1;
      end else begin
         if (post_pending) begin
            check("rdy_after_done", bus.rdy, 1'b1);
            post_pending = 1'b0;
         end
         if (!in_txn) begin
            if (prev[0] && !bus.rdy) begin
               in_txn   = 1'b1;
               acc_tick = mon_tick;
               cnt_x    = 0;
               cnt_y    = 0;
               first_x  = 0;
               first_y  = 0;
               dir_bad  = 1'b0;
               acc_dx   = mx_dir;
               acc_dy   = my_dir;
               check("done_low_at_accept", bus.done, 1'b0);
            end else if (mx_step || my_step) begin
               stray = 1'b1;
            end
         end else begin
            if (mx_dir !== acc_dx || my_dir !== acc_dy) dir_bad = 1'b1;
            if (mx_step) begin
               cnt_x++;
               if (first_x == 0) first_x = mon_tick - acc_tick + 1;
            end
            if (my_step) begin
               cnt_y++;
               if (first_y == 0) first_y = mon_tick - acc_tick + 1;
            end
            if (bus.done) begin
               in_txn       = 1'b0;
               post_pending = 1'b1;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_step: step completed at tick %0d with no accepted trigger", mon_tick);
               end else begin
                  e = exp_q.pop_front();
                  check("accept_tick", acc_tick, e.acc_tick);
                  check("latency", mon_tick - acc_tick + 1, e.lat);
                  check("dir_x", mx_dir, e.dx);
                  check("dir_y", my_dir, e.dy);
                  check("x_pulse_ticks", cnt_x, e.ex ? P : 0);
                  check("y_pulse_ticks", cnt_y, e.ey ? P : 0);
                  check("x_rise_tick", first_x, e.ex ? S + 1 : 0);
                  check("y_rise_tick", first_y, e.ey ? S + 1 : 0);
                  check("dir_stable", dir_bad, 1'b0);
               end
            end
         end
      end
      prev = cur;
   end

   task automatic drive(input logic t, input logic ex, input logic dx,
                        input logic ey, input logic dy, input logic en);
      bus.trigger   = t;
      bus.step_x_en = ex;
      bus.dir_x     = dx;
      bus.step_y_en = ey;
      bus.dir_y     = dy;
      clk_en        = en;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      bus.trigger   = 1'b0;
      bus.step_x_en = 1'b0;
      bus.dir_x     = 1'b0;
      bus.step_y_en = 1'b0;
      bus.dir_y     = 1'b0;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_x_step", mx_step, 1'b0);
      check("rst_x_dir", mx_dir, 1'b0);
      check("rst_y_step", my_step, 1'b0);
      check("rst_y_dir", my_dir, 1'b0);
      check("rst_done", bus.done, 1'b1);
      check("rst_rdy", bus.rdy, 1'b1);
      @(negedge clk);

      // Single X step, positive direction, every cycle a tick.
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(30);

      // Both axes, one tick in four, trigger held across a second tick while busy.
      for (int i = 0; i < 160; i++)
         drive(i < 8, 1'b1, 1'b0, 1'b1, 1'b1, (i % 4) == 0);
      idle(5);

      // No axis enabled: PULSE skipped, directions still latched.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(20);

      // Randomized traffic with random tick gaps and occasional held triggers.
      begin
         int hold = 0;
         for (int i = 0; i < 2000; i++) begin
            if (hold == 0 && $urandom_range(0, 63) == 0) hold = $urandom_range(10, 60);
            drive((hold > 0) || ($urandom_range(0, 7) == 0),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0);
            if (hold > 0) hold--;
         end
      end

      // Trigger held constantly high: back-to-back steps.
      for (int i = 0; i < 200; i++)
         drive(1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      idle(40);

      // Asynchronous reset in the middle of a pulse.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(4);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midpulse_x_step_drop", mx_step, 1'b0);
      check("midpulse_y_step_drop", my_step, 1'b0);
      check("midpulse_done", bus.done, 1'b1);
      check("midpulse_rdy", bus.rdy, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_reset_done", bus.done, 1'b1);
      check("post_reset_rdy", bus.rdy, 1'b1);
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(40);

      check("queue_drained", exp_q.size(), 0);
      check("no_txn_in_flight", in_txn, 1'b0);
      check("no_stray_step", stray, 1'b0);
      check("nontick_stable", nontick_chg, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
